// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// BAUD_DIV is the number of clk cycles per bit (even, >= 8).
// Data is sampled mid-bit. The byte is presented on rx_data and qualified by rdy.
// The consumer acknowledges each byte with clr_rdy.
// Optional build macro UART_RX_FRAME_ERR_EN enables two checks:
// false-start rejection and the stop-bit framing error flag (frm_err).
// Without the macro, frm_err is tied low.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_CNT  = 4'd10;

    typedef enum logic {
        IDLE,
        RECEIVING
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             start_edge;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] baud_cnt;
    logic [8:0]       shift_reg;

    // Two-flop synchronizer for the asynchronous RX pin, plus an edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign rx_data    = shift_reg[7:0];

`ifdef UART_RX_FRAME_ERR_EN
    logic frm_err_q;

    assign frm_err = frm_err_q;

    // Receive FSM with framing checks: counters, shift register, rdy and frm_err.
    // clr_rdy is applied first, so a frame completing in the same cycle still sets rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            shift_reg <= '0;
            rdy       <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy       <= 1'b0;
                frm_err_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= RECEIVING;
                        bit_cnt   <= '0;
                        baud_cnt  <= HALF_LOAD;
                        rdy       <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                RECEIVING: begin
                    if (bit_cnt == LAST_CNT) begin
                        state     <= IDLE;
                        rdy       <= 1'b1;
                        frm_err_q <= ~shift_reg[8];
                    end else if (baud_cnt == '0) begin
                        if ((bit_cnt == '0) && rx_sync) begin
                            // The start bit read high at mid-bit, so the edge was a glitch.
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            shift_reg <= {rx_sync, shift_reg[8:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                            baud_cnt  <= FULL_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign frm_err = 1'b0;

    // Receive FSM: counters, shift register and the rdy flag.
    // clr_rdy is applied first, so a frame completing in the same cycle still sets rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            shift_reg <= '0;
            rdy       <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= RECEIVING;
                        bit_cnt  <= '0;
                        baud_cnt <= HALF_LOAD;
                        rdy      <= 1'b0;
                    end
                end
                RECEIVING: begin
                    if (bit_cnt == LAST_CNT) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end else if (baud_cnt == '0) begin
                        shift_reg <= {rx_sync, shift_reg[8:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        baud_cnt  <= FULL_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1, LSB first.
- Default timing is 50 MHz clk and 9600 baud (divider 5208).
- Receives frames from a UART transmitter over a single wire RX and presents the byte on rx_data, qualified by a set/reset rdy flag.
- Sits between the external RX pin and the command/processing logic; the consumer acknowledges each byte with clr_rdy.

Parameters:
- BAUD_DIV, 5208: clk cycles per bit. Must be even and ≥ 8. Benches may override it to shorten simulation.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  serial line, idle high; asynchronous to clk
- clr_rdy  input  1  consumer acknowledge; clears rdy
- rx_data  output  8  last received byte
- rdy  output  1  byte available; set/reset flop
- frm_err  output  1  framing/stop-bit error flag; constant 0 unless UART_RX_FRAME_ERR_EN is defined

Behaviour:
- Reset values:
  - RX synchronizer flops (two stages plus one edge-history flop) preset to 1.
  - State IDLE; bit_cnt = 0; baud_cnt = 0.
  - 9-bit shift register = 0, so rx_data = 0x00.
  - rdy = 0; frm_err = 0.
- Reset mid-frame aborts the frame immediately. Those reset values apply, and the receiver waits for the next falling edge.
- RX is used only after 2-flop synchronization. A start edge is a synced 1→0 transition (edge-history flop = 1, synced = 0).
- Counters:
  - bit_cnt is 4 bits.
  - baud_cnt is sized for BAUD_DIV-1.
  - A shift occurs when baud_cnt == 0 while in RECEIVING.
- IDLE state:
  - On a start edge: go to RECEIVING, bit_cnt ← 0, baud_cnt ← BAUD_DIV/2 − 1, rdy ← 0.
  - Otherwise stay in IDLE. Counters are held and not decremented.
- RECEIVING state:
  - baud_cnt decrements by 1 each cycle.
  - On a shift: shift_reg ← {RX_synced, shift_reg[8:1]}, bit_cnt ← bit_cnt + 1, baud_cnt ← BAUD_DIV − 1.
  - Sample points: first sample (start bit) is BAUD_DIV/2 cycles after the start-edge cycle; the next 9 follow every BAUD_DIV cycles (mid-bit).
  - When bit_cnt reaches 10 (start, d0..d7, stop sampled): go to IDLE and set rdy = 1 on the next edge.
  - At that point shift_reg[7:0] = d7..d0 and shift_reg[8] = stop bit.
- rx_data = shift_reg[7:0]:
  - Stable from rdy rise until the first shift of the next frame.
  - While the frame is in progress it shows partial data; consumers use it only while rdy = 1.
- rdy:
  - Set on frame completion.
  - Cleared by clr_rdy, or by a start edge detected in IDLE.
  - If clr_rdy coincides with the completion cycle, set wins: rdy = 1.
  - Without clr_rdy, rdy stays high until the next start edge. There is no overrun flag.
- Start edges during RECEIVING are ignored; edge detection is active in IDLE only.
- Latency: rdy rises 2–3 clk after RX reaches mid-stop-bit, which is about 9.5·BAUD_DIV + 3 clk after the RX falling edge.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - False-start rejection: if the first sample (start bit) reads 1, return to IDLE immediately with bit_cnt ← 0. rdy stays 0 and frm_err is unchanged.
  - Stop-bit check: at completion, frm_err ← ~shift_reg[8] (stop sampled 0 → frm_err = 1). rdy is still set and rx_data is still valid.
  - frm_err is cleared under the same conditions as rdy (clr_rdy or start edge).
- Not defined:
  - frm_err is tied to 0.
  - The start-bit sample is ignored and every detected edge yields a full 10-sample frame.

Test Plan (BAUD_DIV = 32 unless noted):
1. Clean frame 0xA5, 1 stop bit, idle after → exactly one rdy rise, about 307 clk after the falling edge; rx_data = 0xA5; frm_err = 0.
2. Back-to-back 0x00 then 0xFF, zero idle gap, no clr_rdy:
   - rdy = 1 with 0x00.
   - rdy drops within 3 clk of the second start edge.
   - rdy rises again with rx_data = 0xFF.
3. After rx_data = 0xA5, pulse clr_rdy for 1 cycle → rdy = 0 the next cycle; rx_data holds 0xA5; a clr_rdy asserted in the completion cycle leaves rdy = 1.
4. Frame 0x3C with stop bit driven 0:
   - Macro defined: rdy = 1, rx_data = 0x3C, frm_err = 1; clr_rdy clears both flags.
   - Macro undefined: frm_err = 0.
5. RX low glitch of 4 clk, then high:
   - Macro defined: no rdy; back in IDLE within 16 clk; a following 0x5A frame is received correctly.
   - Macro undefined: rdy = 1 with rx_data = 0xFF.
6. Assert rst_n low after the 3rd data bit of 0xC3 and release it → rdy = 0, rx_data = 0x00, frm_err = 0; the next frame 0x5A is received correctly with rdy = 1.
